// File: rtl/axis_arb_mux_5_to_1.sv
// Five-source AXI-Stream round-robin merge with bounded bursts and a registered output stage.
// Optional AXIS_MUX_SRC_TAG_EN: output tdest carries the source port index (1..5) instead.
module axis_arb_mux_5_to_1 #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEST_WIDTH = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] axis_in_1_tdata,
    input  logic                  axis_in_1_tvalid,
    input  logic [DEST_WIDTH-1:0] axis_in_1_tdest,
    input  logic [ID_WIDTH-1:0]   axis_in_1_tid,
    output logic                  axis_in_1_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_2_tdata,
    input  logic                  axis_in_2_tvalid,
    input  logic [DEST_WIDTH-1:0] axis_in_2_tdest,
    input  logic [ID_WIDTH-1:0]   axis_in_2_tid,
    output logic                  axis_in_2_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_3_tdata,
    input  logic                  axis_in_3_tvalid,
    input  logic [DEST_WIDTH-1:0] axis_in_3_tdest,
    input  logic [ID_WIDTH-1:0]   axis_in_3_tid,
    output logic                  axis_in_3_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_4_tdata,
    input  logic                  axis_in_4_tvalid,
    input  logic [DEST_WIDTH-1:0] axis_in_4_tdest,
    input  logic [ID_WIDTH-1:0]   axis_in_4_tid,
    output logic                  axis_in_4_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_5_tdata,
    input  logic                  axis_in_5_tvalid,
    input  logic [DEST_WIDTH-1:0] axis_in_5_tdest,
    input  logic [ID_WIDTH-1:0]   axis_in_5_tid,
    output logic                  axis_in_5_tready,
    output logic [DATA_WIDTH-1:0] axis_out_0_tdata,
    output logic                  axis_out_0_tvalid,
    output logic [DEST_WIDTH-1:0] axis_out_0_tdest,
    output logic [ID_WIDTH-1:0]   axis_out_0_tid,
    input  logic                  axis_out_0_tready
);

    localparam int unsigned     CntW    = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    // Ports 1..5 are held internally as indices 0..4.
    logic [4:0]            in_valid;
    logic [4:0]            in_ready;
    logic [DATA_WIDTH-1:0] in_data [5];
    logic [DEST_WIDTH-1:0] in_dest [5];
    logic [ID_WIDTH-1:0]   in_id   [5];

    assign in_valid = {axis_in_5_tvalid, axis_in_4_tvalid, axis_in_3_tvalid,
                       axis_in_2_tvalid, axis_in_1_tvalid};
    assign in_data[0] = axis_in_1_tdata;
    assign in_data[1] = axis_in_2_tdata;
    assign in_data[2] = axis_in_3_tdata;
    assign in_data[3] = axis_in_4_tdata;
    assign in_data[4] = axis_in_5_tdata;
    assign in_dest[0] = axis_in_1_tdest;
    assign in_dest[1] = axis_in_2_tdest;
    assign in_dest[2] = axis_in_3_tdest;
    assign in_dest[3] = axis_in_4_tdest;
    assign in_dest[4] = axis_in_5_tdest;
    assign in_id[0]   = axis_in_1_tid;
    assign in_id[1]   = axis_in_2_tid;
    assign in_id[2]   = axis_in_3_tid;
    assign in_id[3]   = axis_in_4_tid;
    assign in_id[4]   = axis_in_5_tid;

    assign axis_in_1_tready = in_ready[0];
    assign axis_in_2_tready = in_ready[1];
    assign axis_in_3_tready = in_ready[2];
    assign axis_in_4_tready = in_ready[3];
    assign axis_in_5_tready = in_ready[4];

    state_e                state_q, state_d;
    logic [2:0]            grant_q, grant_d;
    logic [2:0]            last_q, last_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DEST_WIDTH-1:0] out_dest_q, out_dest_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

    logic       out_free;
    logic       xfer;
    logic       found;
    logic [2:0] pick;
    logic [2:0] cand;

    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    // Round-robin scan starting just after the last grantee.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        cand  = wrap_inc(last_q);
        for (int i = 0; i < 5; i++) begin
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    assign out_free = !out_valid_q || axis_out_0_tready;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        in_ready = '0;
        xfer     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                in_ready[grant_q] = out_free;
                // A stalled output freezes the grant even if the source drops valid.
                if (out_free) begin
                    if (in_valid[grant_q]) begin
                        xfer = 1'b1;
                        if (cnt_q == CntLast) begin
                            state_d = StIdle;
                            last_d  = grant_q;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else begin
                        state_d = StIdle;
                        last_d  = grant_q;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;
        out_id_d    = out_id_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_q];
            out_id_d    = in_id[grant_q];
`ifdef AXIS_MUX_SRC_TAG_EN
            out_dest_d  = DEST_WIDTH'(grant_q + 3'd1);
`else
            out_dest_d  = in_dest[grant_q];
`endif
        end else if (axis_out_0_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= 3'd0;
            last_q      <= 3'd4;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            out_id_q    <= out_id_d;
        end
    end

    assign axis_out_0_tvalid = out_valid_q;
    assign axis_out_0_tdata  = out_data_q;
    assign axis_out_0_tdest  = out_dest_q;
    assign axis_out_0_tid    = out_id_q;

endmodule

// File: doc/axis_arb_mux_5_to_1.md
Name: axis_arb_mux_5_to_1

Overview:
Merges five AXI-Stream sources (axis_in_1..axis_in_5) onto the single sink axis_out_0. This is the return/upstream direction of the 1-to-5 port-0 fan-out switch. Sources are granted round-robin with a bounded burst lock. The output is fully registered so the merge point does not lengthen the combinational path into the downstream switch.

Parameters:
DATA_WIDTH, 128, tdata width of all ports
DEST_WIDTH, 4, tdest width of all ports
ID_WIDTH, 2, tid width of all ports
MAX_BURST, 4, maximum beats accepted from one grantee before re-arbitration; legal range >= 1

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
axis_in_N_tdata  input  DATA_WIDTH  source N data, N = 1..5
axis_in_N_tvalid  input  1  source N valid
axis_in_N_tdest  input  DEST_WIDTH  source N destination
axis_in_N_tid  input  ID_WIDTH  source N id
axis_in_N_tready  output  1  source N ready
axis_out_0_tdata  output  DATA_WIDTH  merged data, registered
axis_out_0_tvalid  output  1  merged valid, registered
axis_out_0_tdest  output  DEST_WIDTH  merged dest, registered
axis_out_0_tid  output  ID_WIDTH  merged id, registered
axis_out_0_tready  input  1  sink ready

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - axis_out_0_tvalid/tdata/tdest/tid = 0.
  - FSM = IDLE; last_grant = 5, so port 1 has first priority; burst_cnt = 0.
  - All axis_in_N_tready = 0.
- Reset asserted mid-burst: a beat held in the output register is discarded; tvalid is 0 from the next edge.
- FSM states: IDLE and GRANT(p), p = 1..5.
- IDLE:
  - All tready = 0.
  - If any tvalid is high, choose the first valid port scanning last_grant+1, ..., 5, 1, ..., last_grant.
  - Next state is GRANT(p) with burst_cnt = 0.
  - Arbitration costs exactly one bubble cycle.
  - If no tvalid is high, stay in IDLE.
- GRANT(p):
  - axis_in_p_tready = !axis_out_0_tvalid || axis_out_0_tready. This is a combinational path from the sink ready.
  - All other tready = 0.
  - Transfer when axis_in_p_tvalid && axis_in_p_tready: load the output register, set tvalid = 1, burst_cnt += 1.
- Release from GRANT(p):
  - Condition (a): a transfer occurs with burst_cnt+1 == MAX_BURST.
  - Condition (b): axis_in_p_tvalid == 0 in a GRANT cycle.
  - On release: last_grant = p, burst_cnt = 0, next state IDLE.
- Output stall: while axis_out_0_tvalid && !axis_out_0_tready, the register, burst_cnt and state are held. The grant is not released by a stall while tvalid is high.
- Output register:
  - Load on transfer.
  - Otherwise clear tvalid when axis_out_0_tready is high.
  - tdata/tdest/tid stay stable while tvalid is high and tready is low.
- Latency: one cycle from the input handshake to axis_out_0_tvalid.
- Throughput: MAX_BURST beats per MAX_BURST+1 cycles under continuous load.
- Field passthrough: tdest and tid pass through unmodified (unless the macro below is enabled). The block does not inspect tdest; any value is merged.
- burst_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 at rest.
- Simultaneous requests: the round-robin order above is the only tie-break. No fixed priority exists beyond it.

Optional Feature:
Macro: AXIS_MUX_SRC_TAG_EN.
- Defined: axis_out_0_tdest is replaced by the source port index p (1..5), zero-extended to DEST_WIDTH. This lets the downstream demux route replies back by tdest. DEST_WIDTH must be >= 3.
- Undefined: tdest passes through unchanged.

Test Plan:
- Reset: hold rst high 2 cycles with all inputs valid -> all tready = 0, axis_out_0_tvalid = 0, tdata = 0; port 1 is granted first after release.
- Single source, sink ready = 1: port 3 offers tdata 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 (tid = 2, MAX_BURST = 4) -> 1 bubble, then 0xA0..0xA3 on consecutive cycles, 1 bubble, then 0xA4; tid = 2 on all beats.
- Fairness: all five sources valid continuously -> grant order 1, 2, 3, 4, 5, 1 with 4 beats each; exactly 1 idle output cycle between bursts.
- Backpressure: axis_out_0_tready = 0 for 3 cycles after beat 2 of a burst -> output holds beat 2 stable; granted tready = 0; burst_cnt unchanged; the burst completes 4 beats total.
- Early release: port 2 drops tvalid after 2 beats while port 4 is valid -> port 2 is released, next grant is port 4 (not 3), last_grant = 4 after that burst.
- With AXIS_MUX_SRC_TAG_EN: port 5 sends tdest 0x0 -> axis_out_0_tdest = 0x5. Without the macro -> 0x0.
